// File: rtl/camera_stream_tx.sv
// camera_stream_tx: camera pixel-bus transmitter (vsync/href/pclk/data) that
// emits OV7670-style RGB565 frames with selectable test patterns.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        asynchronous active-low reset
//   enable       level request for continuous frame generation
//   mode         pattern select (0 ramp, 1 bars, 2 solid, 3 id), latched at frame start
//   solid_color  RGB565 colour for mode 2, latched at frame start
//   pclk         pixel clock, clk/2 while busy, parked low when idle
//   vsync        frame sync, active high
//   href         line valid, active high
//   data         pixel byte, high byte of each pixel first, 0 when href=0
//   frame_start  one-clk pulse when vsync rises
//   frame_done   one-clk pulse at the end of the last front-porch line
//   frame_count  completed frames, wrapping
//   busy         high from frame start through end of frame
//   checksum     (CAM_TX_CHECKSUM_EN only) 16-bit sum of the last frame's href bytes
//
// Optional build macro: CAM_TX_CHECKSUM_EN adds the checksum output.
module camera_stream_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
`ifdef CAM_TX_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HREF_SLOTS = 2 * H_ACTIVE;
  localparam int unsigned COL_W      = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int unsigned ROW_MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned ROW_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned ROW_MAX    = (ROW_MAX_A > ROW_MAX_B) ? ROW_MAX_A : ROW_MAX_B;
  localparam int unsigned ROW_W      = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               frame_end;
  logic               pclk_q, vsync_q, href_q, busy_q;
  logic               frame_start_q, frame_done_q;
  logic [7:0]         data_q;
  logic [15:0]        frame_count_q;
  logic [1:0]         mode_q;
  logic [15:0]        solid_q;
  logic               href_d;
  logic [7:0]         data_d;
  logic [COL_W-1:0]   x_d;
  logic [2:0]         bar_d;
  logic [15:0]        bar_color;
  logic [15:0]        pixel_d;

  function automatic int unsigned lines_of(state_e s);
    case (s)
      VSYNC:   return VSYNC_LINES;
      VBACK:   return V_BACK;
      ACTIVE:  return V_ACTIVE;
      VFRONT:  return V_FRONT;
      default: return 1;
    endcase
  endfunction

  // Position of the next byte-slot; frame_end marks the final slot of VFRONT.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q + COL_W'(1);
    row_d     = row_q;
    frame_end = 1'b0;
    if (col_q == COL_W'(LINE_SLOTS - 1)) begin
      col_d = '0;
      if (row_q == ROW_W'(lines_of(state_q) - 1)) begin
        row_d = '0;
        case (state_q)
          VSYNC:   state_d = VBACK;
          VBACK:   state_d = ACTIVE;
          ACTIVE:  state_d = VFRONT;
          VFRONT: begin
            frame_end = 1'b1;
            state_d   = enable ? VSYNC : IDLE;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  // Pattern byte for the next slot; even slot carries the pixel's high byte.
  always_comb begin
    x_d   = col_d >> 1;
    bar_d = 3'((32'(x_d) * 32'd8) / H_ACTIVE);
    case (bar_d)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
    case (mode_q)
      2'd1:    pixel_d = bar_color;
      2'd2:    pixel_d = solid_q;
      2'd3:    pixel_d = {frame_count_q[7:0], 8'(row_d)};
      default: pixel_d = 16'h0000;
    endcase
    href_d = (state_d == ACTIVE) && (col_d < COL_W'(HREF_SLOTS));
    data_d = 8'h00;
    if (href_d) begin
      if (mode_q == 2'd0) data_d = 8'(col_d);
      else                data_d = col_d[0] ? pixel_d[7:0] : pixel_d[15:8];
    end
  end

`ifdef CAM_TX_CHECKSUM_EN
  logic [15:0] acc_q;
  logic [15:0] checksum_q;
  assign checksum = checksum_q;
`endif

  // FSM, slot counters and registered bus outputs; bus changes only as pclk falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      pclk_q        <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'h0000;
      busy_q        <= 1'b0;
      mode_q        <= 2'd0;
      solid_q       <= 16'h0000;
`ifdef CAM_TX_CHECKSUM_EN
      acc_q         <= 16'h0000;
      checksum_q    <= 16'h0000;
`endif
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (enable) begin
          state_q       <= VSYNC;
          col_q         <= '0;
          row_q         <= '0;
          pclk_q        <= 1'b0;
          vsync_q       <= 1'b1;
          busy_q        <= 1'b1;
          frame_start_q <= 1'b1;
          mode_q        <= mode;
          solid_q       <= solid_color;
`ifdef CAM_TX_CHECKSUM_EN
          acc_q         <= 16'h0000;
`endif
        end
      end else begin
        pclk_q <= ~pclk_q;
        if (pclk_q) begin
          state_q <= state_d;
          col_q   <= col_d;
          row_q   <= row_d;
          vsync_q <= (state_d == VSYNC);
          href_q  <= href_d;
          data_q  <= data_d;
          busy_q  <= (state_d != IDLE);
`ifdef CAM_TX_CHECKSUM_EN
          acc_q   <= frame_end ? 16'h0000 : acc_q + 16'(data_d);
`endif
          if (frame_end) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
`ifdef CAM_TX_CHECKSUM_EN
            checksum_q    <= acc_q;
`endif
            if (enable) begin
              frame_start_q <= 1'b1;
              mode_q        <= mode;
              solid_q       <= solid_color;
            end
          end
        end
      end
    end
  end

  assign pclk        = pclk_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule
